// File: rtl/uart_byte_transmitter.sv
`default_nettype none
// ============================================================================
// uart_byte_transmitter : one-byte UART transmitter (8N1, LSB first); define
//                         UART_PARITY_EN to insert an even-parity bit.
// Revision: 1.0
// ============================================================================
module uart_byte_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_state,
    output logic       rs232_tx
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [3:0]       LAST_IDX = 4'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      baud_cnt;
    logic [CNT_W-1:0]      baud_cnt_nxt;
    logic [3:0]            bit_idx;
    logic [3:0]            bit_idx_nxt;
    logic [7:0]            data_reg;
    logic [7:0]            data_nxt;
    logic                  start_q;
    logic                  start_edge;
    logic                  tx_nxt;
    logic                  done_nxt;
    logic [FRAME_BITS-1:0] frame;

`ifdef UART_PARITY_EN
    assign frame = {1'b1, ^data_reg, data_reg, 1'b0};
`else
    assign frame = {1'b1, data_reg, 1'b0};
`endif

    assign start_edge = tx_start & ~start_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
            // Track the live level so a request held through reset is not an edge.
            start_q  <= tx_start;
            rs232_tx <= 1'b1;
            tx_state <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            data_reg <= data_nxt;
            start_q  <= tx_start;
            rs232_tx <= tx_nxt;
            tx_state <= (state_nxt == ST_SEND);
            tx_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        data_nxt     = data_reg;
        tx_nxt       = rs232_tx;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (start_edge) begin
                    state_nxt    = ST_SEND;
                    data_nxt     = tx_data;
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    tx_nxt       = 1'b0;
                end
            end
            ST_SEND: begin
                if (baud_cnt == TERM_CNT) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                        tx_nxt      = frame[bit_idx_nxt];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_transmitter.sv
`default_nettype none
// Bench for uart_byte_transmitter: time-based frame model checked every cycle,
// plus literal line patterns for directed frames.
module tb_uart_byte_transmitter;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int B         = 10;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk_in   = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_done;
    logic       tx_state;
    logic       rs232_tx;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int busy_cycles = 0;
    bit cmp_en = 1'b0;

    logic       m_busy = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_prev = 1'b0;
    logic       e_tx   = 1'b1;
    logic       e_state = 1'b0;
    logic       e_done = 1'b0;

    uart_byte_transmitter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .tx_state(tx_state),
        .rs232_tx(rs232_tx)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Model: line value = frame bit number (elapsed clocks / B) since the accept edge.
    always @(posedge clk_in) begin : p_model
        logic busy;
        logic tx;
        logic done;
        logic st_edge;
        int   t;
        busy    = m_busy;
        t       = m_t;
        tx      = 1'b1;
        done    = 1'b0;
        st_edge = tx_start && !m_prev;
        if (!rst_n_in) begin
            busy = 1'b0;
        end else if (busy) begin
            t = t + 1;
            if (t == NBITS * B) begin
                busy = 1'b0;
                done = 1'b1;
            end else begin
                tx = frame_bit(m_byte, t / B);
            end
        end else if (st_edge) begin
            busy   = 1'b1;
            t      = 0;
            tx     = 1'b0;
            m_byte <= tx_data;
        end
        m_prev  <= tx_start;
        m_busy  <= busy;
        m_t     <= t;
        e_tx    <= tx;
        e_state <= busy;
        e_done  <= done;
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check_int("model_rs232_tx", int'(rs232_tx), int'(e_tx));
            check_int("model_tx_state", int'(tx_state), int'(e_state));
            check_int("model_tx_done",  int'(tx_done),  int'(e_done));
            if (tx_done === 1'b1)  done_pulses++;
            if (tx_state === 1'b1) busy_cycles++;
        end
    end

    task automatic tick;
        @(negedge clk_in);
        #1;
    endtask

    task automatic send_capture(input logic [7:0] b, output logic [10:0] bits,
                                output int busy_n, output int done_n);
        int b0;
        int d0;
        b0 = busy_cycles;
        d0 = done_pulses;
        bits = '0;
        tx_data  = b;
        tx_start = 1'b1;
        repeat (5) tick;
        for (int k = 0; k < NBITS; k++) begin
            bits[k] = rs232_tx;
            if (k == 2) tx_data = 8'hFF;
            if (k == 3) tx_start = 1'b0;
            repeat (B) tick;
        end
        repeat (5) tick;
        busy_n = busy_cycles - b0;
        done_n = done_pulses - d0;
    endtask

    initial begin : p_stim
        logic [10:0] bits;
        int busy_n;
        int done_n;
        int d0;
        int b0;
        bit seen;

        rst_n_in = 1'b0;
        tx_start = 1'b1;
        repeat (3) tick;
        cmp_en = 1'b1;
        check_int("reset_tx",    int'(rs232_tx), 1);
        check_int("reset_state", int'(tx_state), 0);
        check_int("reset_done",  int'(tx_done),  0);
        rst_n_in = 1'b1;
        b0 = busy_cycles;
        repeat (30) tick;
        check_int("no_frame_after_reset", busy_cycles - b0, 0);
        tx_start = 1'b0;
        tick;

        send_capture(8'h55, bits, busy_n, done_n);
`ifdef UART_PARITY_EN
        check_int("bits_0x55", int'(bits), 'h4AA);
`else
        check_int("bits_0x55", int'(bits), 'h2AA);
`endif
        check_int("busy_len_0x55", busy_n, NBITS * B);
        check_int("done_cnt_0x55", done_n, 1);

        send_capture(8'hA3, bits, busy_n, done_n);
`ifdef UART_PARITY_EN
        check_int("bits_0xA3", int'(bits), 'h546);
`else
        check_int("bits_0xA3", int'(bits), 'h346);
`endif
        check_int("done_cnt_0xA3", done_n, 1);

`ifdef UART_PARITY_EN
        send_capture(8'h07, bits, busy_n, done_n);
        check_int("bits_0x07_parity", int'(bits), 'h60E);
        check_int("busy_len_0x07", busy_n, 110);
`endif

        // Toggle tx_start every cycle during a frame.
        d0 = done_pulses;
        b0 = busy_cycles;
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        tick;
        for (int i = 0; i < NBITS * B - 5; i++) begin
            tx_start = ~tx_start;
            tick;
        end
        tx_start = 1'b0;
        repeat (15) tick;
        check_int("toggle_done_cnt", done_pulses - d0, 1);
        check_int("toggle_busy_len", busy_cycles - b0, NBITS * B);

        // Restart in the tx_done cycle.
        tx_data  = 8'h81;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < NBITS * B + 20; i++) begin
            tick;
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("done_seen_0x81", int'(seen), 1);
        tx_start = 1'b1;
        tick;
        check_int("b2b_start_bit", int'(rs232_tx), 0);
        check_int("b2b_state",     int'(tx_state), 1);
        tx_start = 1'b0;
        repeat (NBITS * B + 5) tick;

        // Reset 45 cycles into a frame.
        d0 = done_pulses;
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        repeat (44) tick;
        rst_n_in = 1'b0;
        tick;
        check_int("midrst_tx",    int'(rs232_tx), 1);
        check_int("midrst_state", int'(tx_state), 0);
        repeat (2) tick;
        rst_n_in = 1'b1;
        repeat (NBITS * B) tick;
        check_int("midrst_no_done", done_pulses - d0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tx_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) tx_start = ~tx_start;
            rst_n_in = ($urandom_range(0, 1499) != 0);
            tick;
        end
        rst_n_in = 1'b1;
        tx_start = 1'b0;
        repeat (NBITS * B + 5) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
